// File: rtl/wallace_mac_accumulator.sv
// Streaming multiply-accumulate stage: registered 4x4 signed-by-unsigned Wallace multiply
// feeding a saturating signed accumulator that emits one result per in_last-terminated vector.

module wallace_tree_multiplier (
  input  logic signed [3:0] a,
  input  logic        [3:0] b,
  output logic signed [7:0] p
);
  logic [7:0] a_ext;
  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] s1, m1, c1, s2, m2, c2;

  // Partial products are sign-extended to 8 bits; the product always fits, so mod-256 arithmetic is exact
  assign a_ext = {{4{a[3]}}, a};
  assign pp0   = b[0] ? a_ext        : 8'd0;
  assign pp1   = b[1] ? (a_ext << 1) : 8'd0;
  assign pp2   = b[2] ? (a_ext << 2) : 8'd0;
  assign pp3   = b[3] ? (a_ext << 3) : 8'd0;

  assign s1 = pp0 ^ pp1 ^ pp2;
  assign m1 = (pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2);
  assign c1 = m1 << 1;
  assign s2 = s1 ^ c1 ^ pp3;
  assign m2 = (s1 & c1) | (s1 & pp3) | (c1 & pp3);
  assign c2 = m2 << 1;
  assign p  = s2 + c2;
endmodule

module wallace_mac_accumulator #(
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [3:0]       in_a,
  input  logic        [3:0]       in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic sat_hit(input logic signed [ACC_W:0] s);
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    if (sat_hit(s)) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  logic                    rdy_en;
  logic signed [3:0]       a_p1;
  logic        [3:0]       b_p1;
  logic                    last_p1;
  logic                    vld_p1;
  logic signed [7:0]       prod_p1;
  logic signed [ACC_W-1:0] acc_p2;
  logic                    sticky_p2;
  logic signed [ACC_W:0]   sum_p1;
  logic signed [ACC_W-1:0] sum_sat_p1;
  logic                    hit_p1;
  logic                    adv;
  logic                    accept;

  assign adv      = vld_p1 && (!last_p1 || !out_valid || out_ready);
  // rdy_en holds in_ready low until the first edge after reset release
  assign in_ready = rdy_en && (!vld_p1 || adv);
  assign accept   = in_valid && in_ready;

  // S1: operand register
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1    <= in_a;
      b_p1    <= in_b;
      last_p1 <= in_last;
    end
  end

  // S2: multiply, extend, add and saturate
  wallace_tree_multiplier u_mul (
    .a (a_p1),
    .b (b_p1),
    .p (prod_p1)
  );

  assign sum_p1     = {acc_p2[ACC_W-1], acc_p2} + {{(ACC_W-7){prod_p1[7]}}, prod_p1};
  assign sum_sat_p1 = sat_acc(sum_p1);
  assign hit_p1     = sat_hit(sum_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      vld_p1    <= 1'b0;
      acc_p2    <= '0;
      sticky_p2 <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept)   vld_p1 <= 1'b1;
      else if (adv) vld_p1 <= 1'b0;

      if (adv && last_p1) begin
        out_acc   <= sum_sat_p1;
        out_ovf   <= sticky_p2 | hit_p1;
        out_valid <= 1'b1;
        acc_p2    <= '0;
        sticky_p2 <= 1'b0;
      end else begin
        if (adv) begin
          acc_p2    <= sum_sat_p1;
          sticky_p2 <= sticky_p2 | hit_p1;
        end
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end
endmodule
